alu_muldiv_pipe: RTL and testbench

- Parametrised successor to the processor's combinational ALU, used by the pipelined MIPS datapath.
- Adds a registered single-cycle result path, extra logic and shift operations, signed overflow detection, and an iterative multiply/divide unit that writes HI/LO.
- Uses a valid/ready handshake so the hazard unit can stall EX while a mult/div is in progress.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_muldiv_seq.sv | 75 +++++++
 rtl/alu_muldiv_pipe.sv | 109 ++++++++++
 tb/tb_alu_muldiv_pipe.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and helpers shared by the ALU/mult-div pipeline
package alu_pkg;
   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_XOR   = 4'b0011;
   localparam logic [3:0] ALU_SLTU  = 4'b0100;
   localparam logic [3:0] ALU_NOR   = 4'b0101;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLT   = 4'b0111;
   localparam logic [3:0] ALU_SLL   = 4'b1000;
   localparam logic [3:0] ALU_SRL   = 4'b1001;
   localparam logic [3:0] ALU_SRA   = 4'b1010;
   localparam logic [3:0] ALU_RSV   = 4'b1011;
   localparam logic [3:0] ALU_MULT  = 4'b1100;
   localparam logic [3:0] ALU_MULTU = 4'b1101;
   localparam logic [3:0] ALU_DIV   = 4'b1110;
   localparam logic [3:0] ALU_DIVU  = 4'b1111;

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;

   function automatic logic is_muldiv(input logic [3:0] ctrl);
      return ctrl[3] & ctrl[2];
   endfunction
endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative shift-add multiply / restoring divide on magnitudes with sign fix-up
module alu_muldiv_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   logic [2*WIDTH-1:0] p_q, p_d, mul_n, div_n, pneg;
   logic [WIDTH-1:0]   m_q, ma, mb, qn, rn;
   logic [WIDTH:0]     add_s, t, diff;
   logic [SHW-1:0]     cnt_q;
   logic               run_q, div_q, dz_q, neg_a_q, neg_b_q, sa, sb, dz;

   assign sa   = ~op[0] & a[WIDTH-1];
   assign sb   = ~op[0] & b[WIDTH-1];
   assign ma   = sa ? -a : a;
   assign mb   = sb ? -b : b;
   assign dz   = op[1] && b == '0;
   assign done = run_q && cnt_q == SHW'(WIDTH-1);

   // p_q holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
   always_comb begin
      add_s = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
      mul_n = p_q[0] ? {add_s, p_q[WIDTH-1:1]} : {1'b0, p_q[2*WIDTH-1:1]};
      t     = p_q[2*WIDTH-1:WIDTH-1];
      diff  = t - {1'b0, m_q};
      div_n = diff[WIDTH] ? {t[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                          : {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
      p_d   = dz_q ? p_q : div_q ? div_n : mul_n;
      pneg  = -p_q;
      qn    = -p_q[WIDTH-1:0];
      rn    = -p_q[2*WIDTH-1:WIDTH];
      hi    = dz_q ? p_q[2*WIDTH-1:WIDTH]
            : div_q ? (neg_a_q ? rn : p_q[2*WIDTH-1:WIDTH])
            : (neg_a_q ^ neg_b_q) ? pneg[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
      lo    = dz_q ? p_q[WIDTH-1:0]
            : div_q ? ((neg_a_q ^ neg_b_q) ? qn : p_q[WIDTH-1:0])
            : (neg_a_q ^ neg_b_q) ? pneg[WIDTH-1:0] : p_q[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q     <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         run_q   <= 1'b0;
         div_q   <= 1'b0;
         dz_q    <= 1'b0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
      end else if (start) begin
         // a zero divisor skips the iterations and finishes after a single cycle
         p_q     <= dz ? {a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, ma};
         m_q     <= mb;
         cnt_q   <= dz ? SHW'(WIDTH-1) : '0;
         run_q   <= 1'b1;
         div_q   <= op[1];
         dz_q    <= dz;
         neg_a_q <= sa;
         neg_b_q <= sb;
      end else if (run_q) begin
         p_q   <= p_d;
         cnt_q <= cnt_q + 1'b1;
         run_q <= !done;
      end
   end
endmodule

// File: rtl/alu_muldiv_pipe.sv
// alu_muldiv_pipe: registered single-cycle ALU plus iterative HI/LO mult/div behind a valid/ready handshake
module alu_muldiv_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             hilo_we,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   state_e           state_q, state_d;
   logic             accept, md_req, sc_req, seq_done, sc_valid_q, zero_q, ovf_q, ovf_d;
   logic [WIDTH-1:0] result_q, result_d, hi_q, lo_q, seq_hi, seq_lo, sum, dif;

   assign in_ready = state_q == ST_IDLE;
   assign accept   = in_valid && in_ready;
   assign md_req   = accept && is_muldiv(alu_ctrl);
   assign sc_req   = accept && !is_muldiv(alu_ctrl);
   assign sum      = op_a + op_b;
   assign dif      = op_a - op_b;

   always_comb begin
      result_d = '0;
      case (alu_ctrl)
         ALU_AND:  result_d = op_a & op_b;
         ALU_OR:   result_d = op_a | op_b;
         ALU_ADD:  result_d = sum;
         ALU_XOR:  result_d = op_a ^ op_b;
         ALU_SLTU: result_d = {{(WIDTH-1){1'b0}}, op_a < op_b};
         ALU_NOR:  result_d = ~(op_a | op_b);
         ALU_SUB:  result_d = dif;
         ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         ALU_SLL:  result_d = op_b << shamt;
         ALU_SRL:  result_d = op_b >> shamt;
         ALU_SRA:  result_d = $signed(op_b) >>> shamt;
         default:  result_d = '0;
      endcase
      ovf_d = (alu_ctrl == ALU_ADD && op_a[WIDTH-1] == op_b[WIDTH-1] && sum[WIDTH-1] != op_a[WIDTH-1])
           || (alu_ctrl == ALU_SUB && op_a[WIDTH-1] != op_b[WIDTH-1] && dif[WIDTH-1] != op_a[WIDTH-1]);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: state_d = md_req ? (alu_ctrl[1] ? ST_DIV : ST_MUL) : ST_IDLE;
         ST_MUL,
         ST_DIV:  state_d = seq_done ? ST_DONE : state_q;
         default: state_d = ST_IDLE;
      endcase
   end

   alu_muldiv_seq #(.WIDTH(WIDTH), .SHW(SHW)) u_seq (
      .clk   (clk),
      .rst_n (rst_n),
      .start (md_req),
      .op    (alu_ctrl[1:0]),
      .a     (op_a),
      .b     (op_b),
      .done  (seq_done),
      .hi    (seq_hi),
      .lo    (seq_lo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sc_valid_q <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         ovf_q      <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         sc_valid_q <= sc_req;
         if (sc_req) begin
            result_q <= result_d;
            zero_q   <= result_d == '0;
            ovf_q    <= ovf_d;
         end
         if (state_q == ST_DONE) begin
            hi_q <= seq_hi;
            lo_q <= seq_lo;
         end
      end
   end

   // DONE presents the fixed-up result directly so the pulse lands one cycle after the last iteration
   assign hilo_we   = state_q == ST_DONE;
   assign out_valid = sc_valid_q | hilo_we;
   assign result    = result_q;
   assign zero      = zero_q;
   assign overflow  = ovf_q;
   assign hi        = hilo_we ? seq_hi : hi_q;
   assign lo        = hilo_we ? seq_lo : lo_q;
endmodule

// File: tb/tb_alu_muldiv_pipe.sv
// tb_alu_muldiv_pipe: directed vectors with hand-computed results for alu_muldiv_pipe (WIDTH=32)
module tb_alu_muldiv_pipe;
   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
   logic [3:0]  alu_ctrl = '0;
   logic [31:0] op_a = '0, op_b = '0;
   logic [4:0]  shamt = '0;
   logic        in_ready, out_valid, zero, overflow, hilo_we;
   logic [31:0] result, hi, lo;
   int          n_cmp = 0, n_bad = 0;

   alu_muldiv_pipe #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .shamt(shamt),
      .out_valid(out_valid), .result(result), .zero(zero), .overflow(overflow),
      .hilo_we(hilo_we), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
      in_valid = 1'b1;
      alu_ctrl = c;
      op_a     = a;
      op_b     = b;
      shamt    = s;
   endtask

   task automatic sc(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] s, input logic [31:0] er, input logic ez, input logic eo);
      @(negedge clk);
      drive(c, a, b, s);
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, ".valid"}, out_valid, 1);
      chk({tag, ".result"}, result, er);
      chk({tag, ".zero"}, zero, ez);
      chk({tag, ".ovf"}, overflow, eo);
   endtask

   task automatic md(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input int elat, input logic [31:0] keep);
      int   lat;
      logic rdy_bad;
      @(negedge clk);
      chk({tag, ".ready_before"}, in_ready, 1);
      drive(c, a, b, 0);
      @(negedge clk);
      in_valid = 1'b0;
      lat      = 1;
      rdy_bad  = 1'b0;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_bad = 1'b1;
         if (lat == 5) drive(4'b0010, 32'd1, 32'd1, 0);
         if (lat == 6) in_valid = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (in_ready) rdy_bad = 1'b1;
      chk({tag, ".latency"}, lat, elat);
      chk({tag, ".ready_low"}, rdy_bad, 0);
      chk({tag, ".hilo_we"}, hilo_we, 1);
      chk({tag, ".hi"}, hi, eh);
      chk({tag, ".lo"}, lo, el);
      chk({tag, ".result_kept"}, result, keep);
      @(negedge clk);
      chk({tag, ".pulse_end"}, out_valid, 0);
      chk({tag, ".ready_after"}, in_ready, 1);
   endtask

   logic [3:0]  bc [4] = '{4'b0111, 4'b0100, 4'b1010, 4'b0101};
   logic [31:0] ba [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0};
   logic [31:0] bb [4] = '{32'h1, 32'h1, 32'h80000000, 32'h0};
   logic [4:0]  bs [4] = '{5'd0, 5'd0, 5'd4, 5'd0};
   logic [31:0] br [4] = '{32'h1, 32'h0, 32'hF8000000, 32'hFFFFFFFF};

   initial begin
      logic stale;
      repeat (2) @(negedge clk);
      chk("rst.valid", out_valid, 0);
      chk("rst.result", result, 0);
      chk("rst.zero", zero, 0);
      chk("rst.hilo", {hi, lo}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst.ready", in_ready, 1);

      sc("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 0, 1);
      sc("sub_zero", 4'b0110, 32'd5, 32'd5, 0, 32'h0, 1, 0);
      sc("sub_ovf", 4'b0110, 32'h80000000, 32'h1, 0, 32'h7FFFFFFF, 0, 1);
      sc("and", 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hF000F000, 0, 0);
      sc("or", 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hFFF0FFF0, 0, 0);
      sc("xor", 4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h0FF00FF0, 0, 0);
      sc("sll", 4'b1000, 32'h0, 32'h1, 5'd31, 32'h80000000, 0, 0);
      sc("srl", 4'b1001, 32'h0, 32'h80000000, 5'd31, 32'h1, 0, 0);
      sc("rsv", 4'b1011, 32'h12345678, 32'h9, 5'd3, 32'h0, 1, 0);

      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk($sformatf("b2b%0d.valid", i - 1), out_valid, 1);
            chk($sformatf("b2b%0d.result", i - 1), result, br[i-1]);
         end
         if (i < 4) begin
            chk($sformatf("b2b%0d.ready", i), in_ready, 1);
            drive(bc[i], ba[i], bb[i], bs[i]);
         end else begin
            in_valid = 1'b0;
         end
      end

      md("mult", 4'b1100, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 32'hFFFFFFFF);
      md("div", 4'b1110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 32'hFFFFFFFF);
      md("divu", 4'b1111, 32'd100, 32'd7, 32'd2, 32'd14, 33, 32'hFFFFFFFF);
      md("divu0", 4'b1111, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 2, 32'hFFFFFFFF);
      md("div_minneg", 4'b1110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, 32'hFFFFFFFF);
      md("mult_minneg", 4'b1100, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 33, 32'hFFFFFFFF);
      md("multu_max", 4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 32'hFFFFFFFF);

      @(negedge clk);
      drive(4'b1101, 32'hFFFFFFFF, 32'd3, 0);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort.valid", out_valid, 0);
      chk("abort.hilo_we", hilo_we, 0);
      chk("abort.result", result, 0);
      chk("abort.flags", {zero, overflow}, 0);
      chk("abort.hi", hi, 0);
      chk("abort.lo", lo, 0);
      @(negedge clk);
      rst_n = 1'b1;
      stale = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) stale = 1'b1;
      end
      chk("abort.stale", stale, 0);
      chk("abort.ready", in_ready, 1);
      sc("add_after_rst", 4'b0010, 32'd2, 32'd3, 0, 32'd5, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
